// File: rtl/red_pitaya_pid_slew.sv
// -----------------------------------------------------------------------------
// red_pitaya_pid_slew
//
// Output conditioning stage between the PID sum/saturation and one DAC channel.
// It clamps the PID output to a programmable window and limits how far the
// output may move on each update tick. It can also freeze the output (hold) or
// ramp it to a park value (park) to protect the actuator.
//
// Ports
//   clk_i       processing clock
//   rstn_i      synchronous active-low reset
//   dat_i       signed PID output, a new sample every cycle
//   set_lo_i    signed lower clamp
//   set_hi_i    signed upper clamp
//   set_step_i  unsigned maximum |change| per tick; 0 disables slew limiting
//   set_div_i   update period minus 1; 0 updates every cycle
//   set_park_i  signed park value
//   hold_i      freeze the output
//   park_i      ramp the output to set_park_i; takes priority over hold_i
//   dat_o       signed conditioned output (registered)
//   state_o     0 TRACK, 1 HOLD, 2 PARK
//   lim_o       the target on the last TRACK tick was clamped
//   slew_o      the last update was step-limited
//   parked_o    in PARK and dat_o equals set_park_i
// -----------------------------------------------------------------------------
module red_pitaya_pid_slew #(
    parameter int DW   = 14,
    parameter int DIVW = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic signed [DW-1:0] dat_i,
    input  logic signed [DW-1:0] set_lo_i,
    input  logic signed [DW-1:0] set_hi_i,
    input  logic        [DW-1:0] set_step_i,
    input  logic      [DIVW-1:0] set_div_i,
    input  logic signed [DW-1:0] set_park_i,
    input  logic                 hold_i,
    input  logic                 park_i,
    output logic signed [DW-1:0] dat_o,
    output logic           [1:0] state_o,
    output logic                 lim_o,
    output logic                 slew_o,
    output logic                 parked_o
);

    typedef enum logic [1:0] {
        TRACK = 2'd0,
        HOLD  = 2'd1,
        PARK  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic       [DIVW-1:0] cnt;
    logic                  tick;
    logic signed  [DW-1:0] dat;
    logic signed  [DW-1:0] clamped;
    logic signed  [DW-1:0] target;
    logic                  outside;
    logic signed    [DW:0] diff;
    logic           [DW:0] diff_abs;
    logic signed  [DW-1:0] dat_next;
    logic                  slew_next;
    logic                  lim;
    logic                  slew;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: every register uses non-blocking assignment so that all flops
    // sample the values from before the edge, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= TRACK;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state. park wins over hold; neither returns to TRACK.
    always_comb begin
        // NOTE: a default assignment first keeps this block free of latches.
        state_next = TRACK;
        if (park_i) begin
            state_next = PARK;
        end else if (hold_i) begin
            state_next = HOLD;
        end
    end

    // FSM: outputs derived from registers
    always_comb begin
        state_o  = state;
        parked_o = (state == PARK) && (dat == set_park_i);
    end

    // -------------------------------------------------------------------------
    // Update prescaler. Comparing with >= means that lowering set_div_i below
    // the running count produces a tick on the next edge instead of a wrap.
    // -------------------------------------------------------------------------
    assign tick = (cnt >= set_div_i);

    // -------------------------------------------------------------------------
    // Target and step limiting
    // -------------------------------------------------------------------------
    always_comb begin
        // Clamping to hi first and then to lo makes a misconfigured window
        // (lo > hi) resolve to set_lo_i.
        clamped = dat_i;
        if (dat_i > set_hi_i) begin
            clamped = set_hi_i;
        end
        if (clamped < set_lo_i) begin
            clamped = set_lo_i;
        end
        outside = (dat_i < set_lo_i) || (dat_i > set_hi_i);

        target = (state == PARK) ? set_park_i : clamped;

        // One extra bit holds any difference of two DW-bit values exactly.
        diff     = (DW+1)'(target) - (DW+1)'(dat);
        diff_abs = diff[DW] ? (DW+1)'(-diff) : (DW+1)'(diff);

        // When limiting, |diff| > step, so dat +/- step lies strictly between
        // dat and target and cannot leave the DW-bit range.
        if ((set_step_i == '0) || (diff_abs <= {1'b0, set_step_i})) begin
            dat_next  = target;
            slew_next = 1'b0;
        end else if (diff[DW]) begin
            dat_next  = dat - set_step_i;
            slew_next = 1'b1;
        end else begin
            dat_next  = dat + set_step_i;
            slew_next = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt  <= '0;
            dat  <= '0;
            lim  <= 1'b0;
            slew <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + DIVW'(1);

            // HOLD freezes both the value and the slew flag.
            if (tick && (state != HOLD)) begin
                dat  <= dat_next;
                slew <= slew_next;
            end

            if (state != TRACK) begin
                lim <= 1'b0;
            end else if (tick) begin
                lim <= outside;
            end
        end
    end

    assign dat_o  = dat;
    assign lim_o  = lim;
    assign slew_o = slew;

endmodule

// File: tb/tb_red_pitaya_pid_slew.sv
// -----------------------------------------------------------------------------
// Testbench for red_pitaya_pid_slew: directed scenarios with fixed expected
// values, followed by randomized stimulus checked against an integer model.
// -----------------------------------------------------------------------------
module tb_red_pitaya_pid_slew;

    localparam int DW   = 14;
    localparam int DIVW = 16;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic signed [DW-1:0] dat;
    logic signed [DW-1:0] lo;
    logic signed [DW-1:0] hi;
    logic        [DW-1:0] step;
    logic      [DIVW-1:0] div;
    logic signed [DW-1:0] park_val;
    logic                 hold;
    logic                 park;
    logic signed [DW-1:0] dat_o;
    logic           [1:0] state_o;
    logic                 lim_o;
    logic                 slew_o;
    logic                 parked_o;

    int n_cmp = 0;
    int n_err = 0;

    red_pitaya_pid_slew #(.DW(DW), .DIVW(DIVW)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .dat_i      (dat),
        .set_lo_i   (lo),
        .set_hi_i   (hi),
        .set_step_i (step),
        .set_div_i  (div),
        .set_park_i (park_val),
        .hold_i     (hold),
        .park_i     (park),
        .dat_o      (dat_o),
        .state_o    (state_o),
        .lim_o      (lim_o),
        .slew_o     (slew_o),
        .parked_o   (parked_o)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model: plain integer arithmetic on the behavioural rules.
    // Inputs only change at the falling edge, so they are stable here.
    // -------------------------------------------------------------------------
    int m_dat   = 0;
    int m_cnt   = 0;
    int m_state = 0;
    bit m_lim   = 1'b0;
    bit m_slew  = 1'b0;

    always @(posedge clk) begin
        int di, lov, hiv, t, d, st;
        if (!rstn) begin
            m_dat = 0; m_cnt = 0; m_state = 0; m_lim = 0; m_slew = 0;
        end else begin
            di  = dat;
            lov = lo;
            hiv = hi;
            st  = int'(step);
            if (m_cnt >= int'(div)) begin
                m_cnt = 0;
                if (m_state != 1) begin
                    if (m_state == 0) begin
                        t = (di > hiv) ? hiv : di;
                        t = (t < lov) ? lov : t;
                        m_lim = (di < lov) || (di > hiv);
                    end else begin
                        t = park_val;
                    end
                    d = t - m_dat;
                    if (st == 0 || (d < 0 ? -d : d) <= st) begin
                        m_dat = t; m_slew = 0;
                    end else begin
                        m_dat = m_dat + ((d > 0) ? st : -st); m_slew = 1;
                    end
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
            if (m_state != 0) m_lim = 0;
            m_state = park ? 2 : (hold ? 1 : 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset;
        rstn = 1'b0; dat = '0; lo = -14'sd8192; hi = 14'sd8191; step = '0;
        div = '0; park_val = '0; hold = 1'b0; park = 1'b0;
        cyc(3);
        n_cmp++;
        if (dat_o !== 14'sd0 || state_o !== 2'd0 || lim_o !== 1'b0 || slew_o !== 1'b0 || parked_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset: dat_o=%0d state=%0d lim=%b slew=%b parked=%b, required 0/0/0/0/0",
                     dat_o, state_o, lim_o, slew_o, parked_o);
        end
        rstn = 1'b1;
    endtask

    task automatic test_passthrough;
        dat = 14'sd1000;
        cyc(1);
        n_cmp++;
        if (dat_o !== 14'sd1000 || slew_o !== 1'b0) begin
            n_err++;
            $display("FAIL passthrough: dat_o=%0d slew=%b, required 1000/0", dat_o, slew_o);
        end
    endtask

    task automatic test_slew_ramp;
        dat = '0; cyc(1);
        step = 14'd100; dat = 14'sd1000;
        for (int i = 1; i <= 10; i++) begin
            cyc(1);
            n_cmp++;
            if (int'(dat_o) != 100 * i || slew_o !== (i < 10)) begin
                n_err++;
                $display("FAIL slew_ramp[%0d]: dat_o=%0d slew=%b, required %0d/%b",
                         i, dat_o, slew_o, 100 * i, (i < 10));
            end
        end
    endtask

    task automatic test_prescaler;
        step = '0; div = 16'd3; dat = 14'sd2000;
        cyc(3);
        n_cmp++;
        if (dat_o !== 14'sd1000) begin
            n_err++; $display("FAIL prescaler_wait: dat_o=%0d, required 1000", dat_o);
        end
        cyc(1);
        n_cmp++;
        if (dat_o !== 14'sd2000) begin
            n_err++; $display("FAIL prescaler_tick: dat_o=%0d, required 2000", dat_o);
        end
        dat = 14'sd3000;
        cyc(3);
        n_cmp++;
        if (dat_o !== 14'sd2000) begin
            n_err++; $display("FAIL prescaler_wait2: dat_o=%0d, required 2000", dat_o);
        end
        cyc(1);
        n_cmp++;
        if (dat_o !== 14'sd3000) begin
            n_err++; $display("FAIL prescaler_tick2: dat_o=%0d, required 3000", dat_o);
        end
        div = 16'd100; dat = -14'sd1000;
        cyc(5);
        n_cmp++;
        if (dat_o !== 14'sd3000) begin
            n_err++; $display("FAIL prescaler_long: dat_o=%0d, required 3000", dat_o);
        end
        div = 16'd2;
        cyc(1);
        n_cmp++;
        if (dat_o !== -14'sd1000) begin
            n_err++; $display("FAIL prescaler_lower: dat_o=%0d, required -1000", dat_o);
        end
    endtask

    task automatic test_clamp;
        div = '0; step = '0; hi = 14'sd500; lo = -14'sd500; dat = 14'sd8191;
        cyc(1);
        n_cmp++;
        if (dat_o !== 14'sd500 || lim_o !== 1'b1) begin
            n_err++; $display("FAIL clamp_hi: dat_o=%0d lim=%b, required 500/1", dat_o, lim_o);
        end
        dat = -14'sd8192;
        cyc(1);
        n_cmp++;
        if (dat_o !== -14'sd500 || lim_o !== 1'b1) begin
            n_err++; $display("FAIL clamp_lo: dat_o=%0d lim=%b, required -500/1", dat_o, lim_o);
        end
        lo = 14'sd600; hi = 14'sd500; dat = '0;
        cyc(1);
        n_cmp++;
        if (dat_o !== 14'sd600 || lim_o !== 1'b1) begin
            n_err++; $display("FAIL clamp_misconfig: dat_o=%0d lim=%b, required 600/1", dat_o, lim_o);
        end
        lo = -14'sd8192; hi = 14'sd8191; dat = 14'sd100;
        cyc(1);
        n_cmp++;
        if (dat_o !== 14'sd100 || lim_o !== 1'b0) begin
            n_err++; $display("FAIL clamp_inside: dat_o=%0d lim=%b, required 100/0", dat_o, lim_o);
        end
    endtask

    task automatic test_no_wrap_hold;
        step = '0; dat = -14'sd8000; cyc(1);
        step = 14'd8191; dat = 14'sd8191;
        cyc(1);
        n_cmp++;
        if (dat_o !== 14'sd191 || slew_o !== 1'b1) begin
            n_err++; $display("FAIL no_wrap_step: dat_o=%0d slew=%b, required 191/1", dat_o, slew_o);
        end
        cyc(1);
        n_cmp++;
        if (dat_o !== 14'sd8191 || slew_o !== 1'b0) begin
            n_err++; $display("FAIL no_wrap_final: dat_o=%0d slew=%b, required 8191/0", dat_o, slew_o);
        end
        step = '0; dat = -14'sd8000; cyc(1);
        step = 14'd1000; dat = 14'sd8191;
        cyc(1);
        hold = 1'b1;
        cyc(1);
        n_cmp++;
        if (dat_o !== -14'sd6000 || state_o !== 2'd1) begin
            n_err++; $display("FAIL hold_enter: dat_o=%0d state=%0d, required -6000/1", dat_o, state_o);
        end
        cyc(3);
        n_cmp++;
        if (dat_o !== -14'sd6000 || slew_o !== 1'b1) begin
            n_err++; $display("FAIL hold_frozen: dat_o=%0d slew=%b, required -6000/1", dat_o, slew_o);
        end
        hold = 1'b0;
        cyc(1);
        n_cmp++;
        if (dat_o !== -14'sd6000 || state_o !== 2'd0) begin
            n_err++; $display("FAIL hold_exit: dat_o=%0d state=%0d, required -6000/0", dat_o, state_o);
        end
        cyc(1);
        n_cmp++;
        if (dat_o !== -14'sd5000) begin
            n_err++; $display("FAIL hold_resume: dat_o=%0d, required -5000", dat_o);
        end
    endtask

    task automatic test_park;
        int exp_v[4] = '{3000, 2000, 1000, 0};
        step = '0; dat = 14'sd3000; cyc(1);
        step = 14'd1000; park_val = '0; park = 1'b1; hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            n_cmp++;
            if (int'(dat_o) != exp_v[i] || state_o !== 2'd2 || parked_o !== (i == 3)) begin
                n_err++;
                $display("FAIL park_ramp[%0d]: dat_o=%0d state=%0d parked=%b, required %0d/2/%b",
                         i, dat_o, state_o, parked_o, exp_v[i], (i == 3));
            end
        end
        park_val = 14'sd1;
        #1;
        n_cmp++;
        if (parked_o !== 1'b0) begin
            n_err++; $display("FAIL park_value_moved: parked=%b, required 0", parked_o);
        end
        park_val = '0;
        rstn = 1'b0;
        cyc(1);
        n_cmp++;
        if (dat_o !== 14'sd0 || state_o !== 2'd0 || parked_o !== 1'b0) begin
            n_err++;
            $display("FAIL park_reset: dat_o=%0d state=%0d parked=%b, required 0/0/0", dat_o, state_o, parked_o);
        end
        rstn = 1'b1; park = 1'b0; hold = 1'b0;
    endtask

    task automatic test_random;
        logic signed [DW-1:0] tmp;
        for (int i = 0; i < 3000; i++) begin
            rstn     = ($urandom_range(0, 99) != 0);
            dat      = DW'($urandom);
            lo       = DW'($urandom);
            hi       = DW'($urandom);
            if ($urandom_range(0, 3) != 0 && lo > hi) begin
                tmp = lo; lo = hi; hi = tmp;
            end
            step     = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(1, 3000));
            div      = DIVW'($urandom_range(0, 3));
            park_val = DW'($urandom);
            hold     = ($urandom_range(0, 7) == 0);
            park     = ($urandom_range(0, 9) == 0);
            cyc(1);
            n_cmp++;
            if (dat_o !== DW'(m_dat)) begin
                n_err++; $display("FAIL random_dat[%0d]: dat_o=%0d, required %0d", i, dat_o, m_dat);
            end
            n_cmp++;
            if (state_o !== 2'(m_state) || lim_o !== m_lim || slew_o !== m_slew ||
                parked_o !== (m_state == 2 && m_dat == int'(park_val))) begin
                n_err++;
                $display("FAIL random_flags[%0d]: state=%0d lim=%b slew=%b parked=%b, required %0d/%b/%b/%b",
                         i, state_o, lim_o, slew_o, parked_o, m_state, m_lim, m_slew,
                         (m_state == 2 && m_dat == int'(park_val)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_slew_ramp();
        test_prescaler();
        test_clamp();
        test_no_wrap_hold();
        test_park();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
